// File: rtl/pico_pkg.sv
// -----------------------------------------------------------------------------
// pico : shared types and constants for the pico core.
//   modePC            - next-PC mode produced by the instruction decoder
//   PC_W_DEFAULT      - default program counter width
//   STK_DEPTH_DEFAULT - default return-stack depth
// -----------------------------------------------------------------------------
package pico;

    localparam int unsigned PC_W_DEFAULT      = 8;
    localparam int unsigned STK_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        INCREMENT  = 2'd0,
        RELATIVE   = 2'd1,
        SUBROUTINE = 2'd2,
        RETURN     = 2'd3
    } modePC;

endpackage

// File: rtl/pc_ctrl_ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack : LIFO of DEPTH entries, W bits each, for subroutine return
// addresses. Only the level counter is reset; entry contents are don't-care.
//   clk_i, rst_i      - clock, synchronous active-high reset (level only)
//   i_push, i_pop     - push i_data / pop top entry (never both at once)
//   i_data            - value to push
//   o_top             - current top entry (zero when empty)
//   o_full, o_empty   - occupancy flags
//   o_level           - number of occupied entries
// -----------------------------------------------------------------------------
module ret_stack #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [W-1:0]     i_data,
    output logic [W-1:0]     o_top,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    // Index width kept at least 1 so DEPTH=1 still has a legal address.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [2**IDX_W];
    logic [LVL_W-1:0] r_lvl;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_top_idx;

    assign w_wr_idx  = IDX_W'(r_lvl);
    assign w_top_idx = IDX_W'(r_lvl - LVL_W'(1));

    assign o_full  = (r_lvl == LVL_W'(DEPTH));
    assign o_empty = (r_lvl == '0);
    assign o_level = r_lvl;
    assign o_top   = o_empty ? '0 : r_mem[w_top_idx];

    always_ff @(posedge clk_i) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lvl <= '0;
        end else if (i_push && !o_full) begin
            r_lvl <= r_lvl + LVL_W'(1);
        end else if (i_pop && !o_empty) begin
            r_lvl <= r_lvl - LVL_W'(1);
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl : program-counter unit of the pico core. Registers the next
// instruction address from the decoder's PC mode, owns the return stack and
// the sticky halted / stack-overflow flags.
//   clk_i, rst_i - clock, synchronous active-high reset
//   mode_pc_i    - next-PC mode (INCREMENT/RELATIVE/SUBROUTINE/RETURN)
//   halt_i       - halt request (sticky once taken)
//   wfi_i        - stall for one cycle, PC and stack hold
//   offset_i     - signed branch offset for RELATIVE
//   target_i     - absolute call target for SUBROUTINE
//   pc_o         - current instruction address
//   halted_o     - core halted, sticky until reset
//   stk_err_o    - return-stack overflow, sticky until reset
//   stk_lvl_o    - occupied return-stack entries
// -----------------------------------------------------------------------------
module pc_ctrl
    import pico::*;
#(
    parameter int unsigned PC_W      = PC_W_DEFAULT,
    parameter int unsigned OFF_W     = 8,
    parameter int unsigned STK_DEPTH = STK_DEPTH_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  modePC                          mode_pc_i,
    input  logic                           halt_i,
    input  logic                           wfi_i,
    input  logic [OFF_W-1:0]               offset_i,
    input  logic [PC_W-1:0]                target_i,
    output logic [PC_W-1:0]                pc_o,
    output logic                           halted_o,
    output logic                           stk_err_o,
    output logic [$clog2(STK_DEPTH+1)-1:0] stk_lvl_o
);

    localparam int unsigned LVL_W = $clog2(STK_DEPTH + 1);

    logic [PC_W-1:0] r_pc;
    logic            r_halted;
    logic            r_err;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_rel;
    logic [PC_W-1:0] w_top;
    logic            w_full;
    logic            w_empty;
    logic            w_stop;
    logic            w_ovf;
    logic            w_push;
    logic            w_pop;

    assign w_pc_inc = r_pc + PC_W'(1);
    // Size cast of a signed operand sign-extends (or truncates) to PC_W.
    assign w_pc_rel = r_pc + PC_W'($signed(offset_i));

    // Priority chain: reset > halted > overflow > wfi > mode.
    assign w_stop = rst_i || r_halted || halt_i;
    assign w_ovf  = !w_stop && (mode_pc_i == SUBROUTINE) && w_full;
    assign w_push = !w_stop && !wfi_i && (mode_pc_i == SUBROUTINE) && !w_full;
    assign w_pop  = !w_stop && !wfi_i && (mode_pc_i == RETURN) && !w_empty;

    ret_stack #(
        .W     (PC_W),
        .DEPTH (STK_DEPTH),
        .LVL_W (LVL_W)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (stk_lvl_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc     <= '0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_halted || halt_i) begin
            r_halted <= 1'b1;
        end else if (w_ovf) begin
            r_err    <= 1'b1;
            r_halted <= 1'b1;
        end else if (!wfi_i) begin
            unique case (mode_pc_i)
                INCREMENT:  r_pc <= w_pc_inc;
                RELATIVE:   r_pc <= w_pc_rel;
                SUBROUTINE: r_pc <= target_i;
                RETURN:     r_pc <= w_empty ? '0 : w_top;
                default:    r_pc <= r_pc;
            endcase
        end
    end

    assign pc_o      = r_pc;
    assign halted_o  = r_halted;
    assign stk_err_o = r_err;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;
    import pico::*;

    logic       clk = 1'b0;
    logic       rst;
    modePC      mode;
    logic       halt;
    logic       wfi;
    logic [7:0] offset;
    logic [7:0] target;
    logic [7:0] pc;
    logic       halted;
    logic       err;
    logic [2:0] lvl;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    pc_ctrl #(
        .PC_W      (8),
        .OFF_W     (8),
        .STK_DEPTH (4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .mode_pc_i (mode),
        .halt_i    (halt),
        .wfi_i     (wfi),
        .offset_i  (offset),
        .target_i  (target),
        .pc_o      (pc),
        .halted_o  (halted),
        .stk_err_o (err),
        .stk_lvl_o (lvl)
    );

    // One active edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset and advance with INCREMENT to reach a given PC.
    task automatic goto_pc(input logic [7:0] n);
        rst = 1'b1; halt = 1'b0; wfi = 1'b0; mode = INCREMENT;
        step();
        rst = 1'b0;
        for (int i = 0; i < int'(n); i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = INCREMENT; halt = 1'b0; wfi = 1'b0;
        offset = '0; target = '0;
        step(); step();
        rst = 1'b0;
        n_checks++;
        if ({pc, halted, err, lvl} !== {8'h00, 1'b0, 1'b0, 3'd0})
            $display("FAIL reset: pc=%h halted=%b err=%b lvl=%0d expected 00 0 0 0", pc, halted, err, lvl);
        else n_pass++;
    endtask

    task automatic test_increment();
        logic [7:0] exp_pc;
        goto_pc(8'd0);
        exp_pc = 8'h00;
        for (int i = 0; i < 260; i++) begin
            step();
            exp_pc = exp_pc + 8'd1;
            n_checks++;
            if (pc !== exp_pc)
                $display("FAIL increment[%0d]: pc=%h expected %h", i, pc, exp_pc);
            else n_pass++;
        end
        n_checks++;
        if (pc !== 8'h04) $display("FAIL increment_end: pc=%h expected 04", pc);
        else n_pass++;
    endtask

    task automatic test_relative();
        goto_pc(8'h10);
        mode = RELATIVE; offset = 8'hFE;
        step();
        n_checks++;
        if (pc !== 8'h0E) $display("FAIL rel_back2: pc=%h expected 0e", pc);
        else n_pass++;
        offset = 8'h00;
        step();
        n_checks++;
        if (pc !== 8'h0E) $display("FAIL rel_zero: pc=%h expected 0e", pc);
        else n_pass++;
        offset = 8'h05;
        step();
        n_checks++;
        if (pc !== 8'h13) $display("FAIL rel_fwd5: pc=%h expected 13", pc);
        else n_pass++;
        goto_pc(8'h01);
        mode = RELATIVE; offset = 8'hFC;
        step();
        n_checks++;
        if (pc !== 8'hFD) $display("FAIL rel_wrap_under: pc=%h expected fd", pc);
        else n_pass++;
        offset = 8'h7F;
        step();
        n_checks++;
        if (pc !== 8'h7C) $display("FAIL rel_wrap_over: pc=%h expected 7c", pc);
        else n_pass++;
    endtask

    task automatic test_call_return();
        goto_pc(8'h05);
        mode = SUBROUTINE; target = 8'h40;
        step();
        n_checks++;
        if ({pc, lvl} !== {8'h40, 3'd1}) $display("FAIL call: pc=%h lvl=%0d expected 40 1", pc, lvl);
        else n_pass++;
        mode = INCREMENT;
        step(); step();
        n_checks++;
        if ({pc, lvl} !== {8'h42, 3'd1}) $display("FAIL call_body: pc=%h lvl=%0d expected 42 1", pc, lvl);
        else n_pass++;
        mode = RETURN;
        step();
        n_checks++;
        if ({pc, lvl} !== {8'h06, 3'd0}) $display("FAIL return: pc=%h lvl=%0d expected 06 0", pc, lvl);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        goto_pc(8'h06);
        mode = SUBROUTINE; target = 8'h80;
        step();
        mode = RETURN;
        step();
        n_checks++;
        if ({pc, lvl} !== {8'h07, 3'd0}) $display("FAIL call_then_ret: pc=%h lvl=%0d expected 07 0", pc, lvl);
        else n_pass++;
        // Call at 0xFF pushes the wrapped return address 0x00.
        goto_pc(8'hFF);
        mode = SUBROUTINE; target = 8'h22;
        step();
        mode = RETURN;
        step();
        n_checks++;
        if ({pc, lvl} !== {8'h00, 3'd0}) $display("FAIL call_wrap_ret: pc=%h lvl=%0d expected 00 0", pc, lvl);
        else n_pass++;
    endtask

    task automatic test_nested_unwind();
        logic [7:0] exp_ret [4];
        exp_ret[0] = 8'h31; exp_ret[1] = 8'h21; exp_ret[2] = 8'h11; exp_ret[3] = 8'h01;
        goto_pc(8'h00);
        mode = SUBROUTINE;
        target = 8'h10; step();
        target = 8'h20; step();
        target = 8'h30; step();
        target = 8'h40; step();
        n_checks++;
        if ({pc, lvl, err} !== {8'h40, 3'd4, 1'b0}) $display("FAIL nest4: pc=%h lvl=%0d err=%b expected 40 4 0", pc, lvl, err);
        else n_pass++;
        mode = RETURN;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({pc, lvl} !== {exp_ret[i], 3'(3 - i)})
                $display("FAIL unwind[%0d]: pc=%h lvl=%0d expected %h %0d", i, pc, lvl, exp_ret[i], 3 - i);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        goto_pc(8'h00);
        mode = SUBROUTINE;
        target = 8'h10; step();
        target = 8'h20; step();
        target = 8'h30; step();
        target = 8'h40; step();
        n_checks++;
        if (lvl !== 3'd4) $display("FAIL ovf_lvl4: lvl=%0d expected 4", lvl);
        else n_pass++;
        target = 8'h50; wfi = 1'b1;    // overflow outranks wfi
        step();
        wfi = 1'b0;
        n_checks++;
        if ({pc, halted, err, lvl} !== {8'h40, 1'b1, 1'b1, 3'd4})
            $display("FAIL ovf: pc=%h halted=%b err=%b lvl=%0d expected 40 1 1 4", pc, halted, err, lvl);
        else n_pass++;
        mode = RETURN; step();
        mode = INCREMENT; step();
        mode = RELATIVE; offset = 8'h10; step();
        n_checks++;
        if ({pc, halted, err, lvl} !== {8'h40, 1'b1, 1'b1, 3'd4})
            $display("FAIL ovf_frozen: pc=%h halted=%b err=%b lvl=%0d expected 40 1 1 4", pc, halted, err, lvl);
        else n_pass++;
        rst = 1'b1; step(); rst = 1'b0;
        n_checks++;
        if ({pc, halted, err, lvl} !== {8'h00, 1'b0, 1'b0, 3'd0})
            $display("FAIL ovf_reset: pc=%h halted=%b err=%b lvl=%0d expected 00 0 0 0", pc, halted, err, lvl);
        else n_pass++;
    endtask

    task automatic test_ret_empty();
        goto_pc(8'h33);
        mode = RETURN;
        step();
        n_checks++;
        if ({pc, lvl, err} !== {8'h00, 3'd0, 1'b0}) $display("FAIL ret_empty: pc=%h lvl=%0d err=%b expected 00 0 0", pc, lvl, err);
        else n_pass++;
    endtask

    task automatic test_wfi();
        goto_pc(8'h20);
        wfi = 1'b1;
        mode = INCREMENT;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin mode = SUBROUTINE; target = 8'h90; end
            step();
            n_checks++;
            if ({pc, lvl, halted} !== {8'h20, 3'd0, 1'b0})
                $display("FAIL wfi_hold[%0d]: pc=%h lvl=%0d halted=%b expected 20 0 0", i, pc, lvl, halted);
            else n_pass++;
        end
        wfi = 1'b0; mode = INCREMENT;
        step();
        n_checks++;
        if (pc !== 8'h21) $display("FAIL wfi_release: pc=%h expected 21", pc);
        else n_pass++;
    endtask

    task automatic test_halt();
        goto_pc(8'h07);
        halt = 1'b1; mode = SUBROUTINE; target = 8'h60;
        step();
        halt = 1'b0;
        n_checks++;
        if ({pc, halted, err, lvl} !== {8'h07, 1'b1, 1'b0, 3'd0})
            $display("FAIL halt: pc=%h halted=%b err=%b lvl=%0d expected 07 1 0 0", pc, halted, err, lvl);
        else n_pass++;
        mode = INCREMENT; step();
        mode = SUBROUTINE; step();
        n_checks++;
        if ({pc, halted, lvl} !== {8'h07, 1'b1, 3'd0})
            $display("FAIL halt_sticky: pc=%h halted=%b lvl=%0d expected 07 1 0", pc, halted, lvl);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        goto_pc(8'h03);
        mode = SUBROUTINE; target = 8'hA0;
        step();
        n_checks++;
        if ({pc, lvl} !== {8'hA0, 3'd1}) $display("FAIL mid_pre: pc=%h lvl=%0d expected a0 1", pc, lvl);
        else n_pass++;
        rst = 1'b1; mode = INCREMENT;
        step();
        rst = 1'b0;
        n_checks++;
        if ({pc, halted, err, lvl} !== {8'h00, 1'b0, 1'b0, 3'd0})
            $display("FAIL mid_reset: pc=%h halted=%b err=%b lvl=%0d expected 00 0 0 0", pc, halted, err, lvl);
        else n_pass++;
        step();
        n_checks++;
        if (pc !== 8'h01) $display("FAIL mid_resume: pc=%h expected 01", pc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_increment();
        test_relative();
        test_call_return();
        test_back_to_back();
        test_nested_unwind();
        test_overflow();
        test_ret_empty();
        test_wfi();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter unit for the pico core, directly downstream of the instruction decoder. It consumes the decoder's PC mode, halt and wait-for-interrupt outputs and registers the next instruction address. It owns the subroutine return-address stack and the sticky halted state. Its `pc_o` drives instruction fetch, which feeds the op code back into the decoder.

## Interface
Parameters:
- `PC_W`, 8: program counter width; addresses wrap modulo 2^PC_W.
- `OFF_W`, 8: width of the two's-complement branch offset.
- `STK_DEPTH`, 4: return-stack entries, ≥1.

Ports:
- `clk_i`  in  1  the single core clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `mode_pc_i`  in  modePC  next-PC mode from the decoder: INCREMENT, RELATIVE, SUBROUTINE or RETURN.
- `halt_i`  in  1  halt request from the decoder.
- `wfi_i`  in  1  wait-for-interrupt stall from the decoder; already gated by the external interrupt.
- `offset_i`  in  OFF_W  signed branch offset, used when mode is RELATIVE.
- `target_i`  in  PC_W  absolute call target, used when mode is SUBROUTINE.
- `pc_o`  out  PC_W  current instruction address.
- `halted_o`  out  1  core halted; sticky until reset.
- `stk_err_o`  out  1  return-stack overflow; sticky until reset.
- `stk_lvl_o`  out  $clog2(STK_DEPTH+1)  number of occupied stack entries.

## Operation
- Reset values: `pc_o`=0, `halted_o`=0, `stk_err_o`=0, `stk_lvl_o`=0. Stack contents are don't-care.
- Per-edge priority, highest first:
  1. `rst_i`
  2. halted (`halted_o`=1 or `halt_i`=1)
  3. stack overflow
  4. `wfi_i`
  5. `mode_pc_i`
- Halted:
  - Set `halted_o`=1.
  - `pc_o` holds. The PC stays at the halting instruction.
  - The stack is frozen.
  - All other inputs are ignored until reset.
- `wfi_i`=1: `pc_o` and the stack hold for that cycle only; nothing is latched.
- INCREMENT: `pc_o` ← `pc_o`+1, wrapping from 2^PC_W−1 to 0.
- RELATIVE: `pc_o` ← `pc_o` + sign-extended `offset_i`, computed in PC_W bits and wrapping both ways. A zero offset holds the PC.
- SUBROUTINE:
  - Stack not full: push `pc_o`+1 (wrapped), `stk_lvl_o`+1, then `pc_o` ← `target_i`.
  - Stack full: overflow. Set `stk_err_o` and `halted_o`. `pc_o` holds and nothing is pushed.
- RETURN:
  - Stack not empty: `pc_o` ← top entry, pop, `stk_lvl_o`−1.
  - Stack empty: `pc_o` ← 0 and the level stays 0. This is the defined recovery path for unknown op codes.
- The `modePC` type is closed. No other values exist, and the default branch is unreachable.

## Timing
- Single-cycle next-PC: `mode_pc_i`, `offset_i` and `target_i` are sampled on the same edge that updates `pc_o`. These inputs are combinational from the decoder, based on the instruction at the current `pc_o`.
- All outputs are registered and have no combinational input-to-output paths.
- A pushed entry is visible to a RETURN on the very next cycle (call followed immediately by return).
- Reset asserted mid-operation clears all state on that edge. `pc_o` is 0 in the cycle after the edge.
- `halted_o` rises on the edge that samples `halt_i` or an overflow. `pc_o` is unchanged on that edge.

## Structure
- The `modePC` enum lives in package `pico`.
- Add `PC_W` and `STK_DEPTH` defaults to `pico` as shared constants.
- Sub-module `ret_stack`: a LIFO holding STK_DEPTH×PC_W entries.
  - Inputs: push, pop, data.
  - Outputs: top, full, empty, level.
  - It has synchronous reset of the level only.
  - Push and pop are never asserted together.
- `pc_ctrl` contains the priority logic, the PC register and the sticky flags.

## Test plan
- Reset, then INCREMENT ×260 with PC_W=8 → `pc_o` counts 0..255, wraps to 0, ends at 4.
- At PC 0x10, RELATIVE offset 0xFE (−2) → next PC 0x0E. At PC 0x01, offset 0xFC → next PC 0xFD.
- SUBROUTINE target 0x40 at PC 0x05, INCREMENT ×2, RETURN:
  - Sequence 0x05 → 0x40 → 0x41 → 0x42 → 0x06.
  - `stk_lvl_o` goes 0 → 1 → 0.
- 4 nested calls, then a 5th call with STK_DEPTH=4:
  - After the 4 calls `stk_lvl_o`=4.
  - The 5th call sets `stk_err_o`=1 and `halted_o`=1, and `pc_o` holds at the 5th call's address.
  - Further modes are ignored until `rst_i`.
- RETURN with the stack empty at PC 0x33 → `pc_o`=0 and `stk_lvl_o` stays 0.
- `wfi_i` high for 3 cycles at PC 0x20, then low with INCREMENT → PC holds at 0x20 for 3 cycles, then 0x21.
- `halt_i` and SUBROUTINE together at PC 0x07 → PC holds at 0x07 and the stack is not pushed.
- `rst_i` pulsed mid-sequence → next cycle all outputs are 0.
